// File: rtl/rgb_led_pkg.sv
// rgb_led_pkg
//   Shared definitions for the RGB LED sequencer: the colour-state
//   encoding, the {r,g,b} mask of each colour, and helpers that step
//   through the colour cycle and look up the mask for a state.
package rgb_led_pkg;

  // Colour states; the numeric values are visible on state_o
  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_RED   = 3'd1,
    ST_GREEN = 3'd2,
    ST_BLUE  = 3'd3,
    ST_WHITE = 3'd4
  } state_t;

  // LED masks, bit order {red, green, blue}
  localparam logic [2:0] MASK_OFF   = 3'b000;
  localparam logic [2:0] MASK_RED   = 3'b100;
  localparam logic [2:0] MASK_GREEN = 3'b010;
  localparam logic [2:0] MASK_BLUE  = 3'b001;
  localparam logic [2:0] MASK_WHITE = 3'b111;

  // Colour that follows s in the running cycle RED->GREEN->BLUE->WHITE->RED.
  // OFF (and any illegal code) enters the cycle at RED.
  function automatic state_t next_colour(input state_t s);
    case (s)
      ST_RED:   next_colour = ST_GREEN;
      ST_GREEN: next_colour = ST_BLUE;
      ST_BLUE:  next_colour = ST_WHITE;
      default:  next_colour = ST_RED;
    endcase
  endfunction

  // Which LEDs a state lights; illegal codes stay dark
  function automatic logic [2:0] colour_mask(input state_t s);
    case (s)
      ST_RED:   colour_mask = MASK_RED;
      ST_GREEN: colour_mask = MASK_GREEN;
      ST_BLUE:  colour_mask = MASK_BLUE;
      ST_WHITE: colour_mask = MASK_WHITE;
      default:  colour_mask = MASK_OFF;
    endcase
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// pwm_gen
//   Free-running PWM used to dim the RGB LED. The counter wraps every
//   2**PWM_BITS cycles; the requested duty is captured only on the last
//   count of a period so a duty change never truncates or stretches the
//   pulse already in progress.
// Ports
//   clk     in   1         system clock
//   rst     in   1         asynchronous active-high reset
//   duty_i  in   PWM_BITS  requested on-time in clk cycles per period
//   pwm_on  out  1         high while the counter is below the active duty
module pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                pwm_on
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_q;

  // Counter wraps by natural overflow; duty reload at the period boundary
  // means the new value governs the period that starts at count 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (pwm_cnt == '1) begin
        duty_q <= duty_i;
      end
    end
  end

  // Duty 0 never fires; full-scale duty leaves exactly one dark cycle
  assign pwm_on = (pwm_cnt < duty_q);

endmodule

// File: rtl/rgb_led_sequencer.sv
// rgb_led_sequencer
//   Steps the on-board RGB LED through OFF -> RED -> GREEN -> BLUE ->
//   WHITE -> RED ..., spending STEP_TICKS blink-divider ticks in each
//   colour, and dims the lit colour(s) with a free-running PWM.
// Ports
//   clk       in   1         system clock (internal oscillator)
//   rst       in   1         asynchronous active-high reset
//   tick_i    in   1         one-cycle strobe from the blink divider
//   enable_i  in   1         1 = run the sequence, 0 = force dark / OFF
//   duty_i    in   PWM_BITS  brightness; LED on while pwm count < duty
//   redled    out  1         red drive, registered, active-high
//   greenled  out  1         green drive, registered, active-high
//   blueled   out  1         blue drive, registered, active-high
//   state_o   out  3         current colour state code
module rgb_led_sequencer
  import rgb_led_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int STEP_TICKS = 2,
  parameter int STEP_BITS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_i,
  input  logic                enable_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                redled,
  output logic                greenled,
  output logic                blueled,
  output logic [2:0]          state_o
);

  localparam logic [STEP_BITS-1:0] STEP_LAST = STEP_BITS'(STEP_TICKS - 1);

  state_t               state;
  state_t               state_nxt;
  logic [STEP_BITS-1:0] step_cnt;
  logic [STEP_BITS-1:0] step_nxt;
  logic                 pwm_on;
  logic [2:0]           led_nxt;

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk    (clk),
    .rst    (rst),
    .duty_i (duty_i),
    .pwm_on (pwm_on)
  );

  // State and step counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_OFF;
      step_cnt <= '0;
    end else begin
      state    <= state_nxt;
      step_cnt <= step_nxt;
    end
  end

  // Disable wins over a coincident tick. OFF leaves on the first tick;
  // running colours advance after STEP_TICKS ticks.
  always_comb begin
    state_nxt = state;
    step_nxt  = step_cnt;
    if (!enable_i) begin
      state_nxt = ST_OFF;
      step_nxt  = '0;
    end else if (tick_i) begin
      if (state == ST_OFF) begin
        state_nxt = ST_RED;
        step_nxt  = '0;
      end else if (step_cnt == STEP_LAST) begin
        state_nxt = next_colour(state);
        step_nxt  = '0;
      end else begin
        step_nxt = step_cnt + STEP_BITS'(1);
      end
    end
  end

  assign led_nxt = colour_mask(state) & {3{pwm_on}};

  // Registered LED drive so the pins never see comparator glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redled   <= 1'b0;
      greenled <= 1'b0;
      blueled  <= 1'b0;
    end else begin
      redled   <= led_nxt[2];
      greenled <= led_nxt[1];
      blueled  <= led_nxt[0];
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// tb_rgb_led_sequencer
//   Directed bench for rgb_led_sequencer with default parameters
//   (PWM_BITS=8, STEP_TICKS=2). cyc counts clk edges since the last reset
//   release, so the DUT's PWM count after edge k is k mod 256 and the LED
//   value registered at edge k reflects count (k-1) mod 256.
module tb_rgb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_i;
  logic       enable_i;
  logic [7:0] duty_i;
  logic       redled;
  logic       greenled;
  logic       blueled;
  logic [2:0] state_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int cnt_r;
  int cnt_g;
  int cnt_b;

  logic [2:0] exp_state [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4};
  logic [2:0] exp_rgb   [8] = '{3'b100, 3'b100, 3'b010, 3'b010,
                                3'b001, 3'b001, 3'b111, 3'b111};

  rgb_led_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .tick_i   (tick_i),
    .enable_i (enable_i),
    .duty_i   (duty_i),
    .redled   (redled),
    .greenled (greenled),
    .blueled  (blueled),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  // Drive all inputs at once
  task automatic applyStimulus(input logic en, input logic tk, input logic [7:0] dt);
    enable_i = en;
    tick_i   = tk;
    duty_i   = dt;
  endtask

  // Compare one observed value with its hand-computed expectation
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance n edges, landing 1 time unit after the last one
  task automatic stepClk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // One-cycle tick with the given enable/duty
  task automatic tickOnce(input logic en, input logic [7:0] dt);
    applyStimulus(en, 1'b1, dt);
    stepClk(1);
    applyStimulus(en, 1'b0, dt);
  endtask

  // Assert reset, confirm outputs go dark without a clock edge, release
  // between edges and restart the edge count
  task automatic doReset(input string tag);
    rst = 1'b1;
    #1;
    checkOutput({tag, "_rgb"}, int'({redled, greenled, blueled}), 0);
    checkOutput({tag, "_state"}, int'(state_o), 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    cyc = 0;
  endtask

  // Count LED high cycles over n edges
  task automatic countLeds(input int n);
    cnt_r = 0;
    cnt_g = 0;
    cnt_b = 0;
    for (int i = 0; i < n; i++) begin
      stepClk(1);
      cnt_r += int'(redled);
      cnt_g += int'(greenled);
      cnt_b += int'(blueled);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 8'd255);
    doReset("reset_init");

    // First duty load happens at edge 256; no tick yet so still OFF
    stepClk(256);
    checkOutput("idle_off_state", int'(state_o), 0);
    checkOutput("idle_off_rgb", int'({redled, greenled, blueled}), 0);

    // Full-brightness colour walk, two ticks per colour
    for (int t = 0; t < 8; t++) begin
      tickOnce(1'b1, 8'd255);
      checkOutput($sformatf("seq_state_%0d", t), int'(state_o), int'(exp_state[t]));
      stepClk(1);
      checkOutput($sformatf("seq_rgb_%0d", t), int'({redled, greenled, blueled}),
                  int'(exp_rgb[t]));
      stepClk(1);
    end

    // Reset while WHITE is lit, then restart from OFF
    $display("[TB] reset mid-sequence");
    doReset("reset_lit");
    tickOnce(1'b1, 8'd64);
    checkOutput("restart_red_state", int'(state_o), 1);

    // Duty 64 in RED over one aligned period (edges 257..512)
    stepClk(255);
    countLeds(256);
    checkOutput("duty64_red_count", cnt_r, 64);
    checkOutput("duty64_green_count", cnt_g, 0);
    checkOutput("duty64_blue_count", cnt_b, 0);

    // Duty raised to 192 with pwm count at 100: this period keeps 64
    cnt_r = 0;
    for (int i = 1; i <= 256; i++) begin
      stepClk(1);
      cnt_r += int'(redled);
      if (i == 100) applyStimulus(1'b1, 1'b0, 8'd192);
    end
    checkOutput("duty_change_old_period", cnt_r, 64);
    countLeds(256);
    checkOutput("duty_change_new_period", cnt_r, 192);

    // Walk RED -> WHITE, then duty 0 from the next period
    for (int t = 0; t < 6; t++) tickOnce(1'b1, 8'd0);
    checkOutput("white_state", int'(state_o), 4);
    stepClk(1);
    checkOutput("white_lit_rgb", int'({redled, greenled, blueled}), 7);
    stepClk(249);
    countLeds(256);
    checkOutput("duty0_any_high", cnt_r + cnt_g + cnt_b, 0);
    checkOutput("duty0_state", int'(state_o), 4);

    // Walk WHITE -> BLUE at full duty, then drop enable with a tick
    for (int t = 0; t < 6; t++) tickOnce(1'b1, 8'd255);
    checkOutput("blue_state", int'(state_o), 3);
    stepClk(250);
    stepClk(1);
    checkOutput("blue_lit_rgb", int'({redled, greenled, blueled}), 1);
    applyStimulus(1'b0, 1'b1, 8'd255);
    stepClk(1);
    checkOutput("disable_state", int'(state_o), 0);
    applyStimulus(1'b0, 1'b0, 8'd255);
    stepClk(1);
    checkOutput("disable_rgb", int'({redled, greenled, blueled}), 0);
    tickOnce(1'b1, 8'd255);
    checkOutput("reenable_state", int'(state_o), 1);
    stepClk(1);
    checkOutput("reenable_rgb", int'({redled, greenled, blueled}), 4);

    // Full-scale duty: dark for exactly one cycle per period
    stepClk(251);
    countLeds(256);
    checkOutput("duty255_red_count", cnt_r, 255);
    checkOutput("duty255_gb_count", cnt_g + cnt_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
